// File: rtl/upg_arbiter_pkg.sv
// ============================================================================
// upg_arbiter_pkg : shared state encoding and memory address constants
// Revision 1.0
// ============================================================================
`default_nettype none

package upg_arbiter_pkg;

  localparam int MEM_AW           = 14;
  localparam int UPG_DMEM_SEL_BIT = 14;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_PROG  = 2'd2,
    ST_EXIT  = 2'd3
  } upg_state_t;

endpackage

`default_nettype wire

// File: rtl/upg_mem_mux.sv
// ============================================================================
// upg_mem_mux : steers the instruction/data memory write ports between the CPU
//               and the UART programmer according to the arbiter state
// Revision 1.0
// ============================================================================
`default_nettype none

module upg_mem_mux
  import upg_arbiter_pkg::*;
(
  input  logic                      rst,
  input  upg_state_t                state,
  input  logic                      upg_wen,
  input  logic [UPG_DMEM_SEL_BIT:0] upg_adr,
  input  logic [31:0]               upg_dat,
  input  logic                      cpu_dwen,
  input  logic [MEM_AW-1:0]         cpu_dadr,
  input  logic [31:0]               cpu_ddat,
  output logic                      imem_wen,
  output logic [MEM_AW-1:0]         imem_adr,
  output logic [31:0]               imem_dat,
  output logic                      dmem_wen,
  output logic [MEM_AW-1:0]         dmem_adr,
  output logic [31:0]               dmem_dat
);

  always_comb begin
    imem_wen = 1'b0;
    imem_adr = '0;
    imem_dat = '0;
    dmem_wen = 1'b0;
    dmem_adr = '0;
    dmem_dat = '0;
    case (state)
      ST_RUN: begin
        dmem_wen = cpu_dwen;
        dmem_adr = cpu_dadr;
        dmem_dat = cpu_ddat;
      end
      ST_PROG: begin
        imem_wen = upg_wen & ~upg_adr[UPG_DMEM_SEL_BIT];
        dmem_wen = upg_wen &  upg_adr[UPG_DMEM_SEL_BIT];
        imem_adr = upg_adr[MEM_AW-1:0];
        imem_dat = upg_dat;
        dmem_adr = upg_adr[MEM_AW-1:0];
        dmem_dat = upg_dat;
      end
      default: ;
    endcase
    // A write coinciding with reset must not land in either memory
    if (rst) begin
      imem_wen = 1'b0;
      dmem_wen = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/upg_arbiter.sv
// ============================================================================
// upg_arbiter : UART program-load sequencer; holds the CPU in reset while the
//               UART programmer owns the instruction and data memories
// Revision 1.0
// ============================================================================
`default_nettype none

module upg_arbiter
  import upg_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_req,
  input  logic                      upg_wen_i,
  input  logic [UPG_DMEM_SEL_BIT:0] upg_adr_i,
  input  logic [31:0]               upg_dat_i,
  input  logic                      upg_done_i,
  input  logic                      cpu_dwen_i,
  input  logic [MEM_AW-1:0]         cpu_dadr_i,
  input  logic [31:0]               cpu_ddat_i,
  output logic                      imem_wen_o,
  output logic [MEM_AW-1:0]         imem_adr_o,
  output logic [31:0]               imem_dat_o,
  output logic                      dmem_wen_o,
  output logic [MEM_AW-1:0]         dmem_adr_o,
  output logic [31:0]               dmem_dat_o,
  output logic                      upg_rst_o,
  output logic                      cpu_rst_o,
  output logic [1:0]                mode_o,
  output logic [15:0]               word_cnt_o,
  output logic                      err_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  upg_state_t       state;
  upg_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [15:0]      word_cnt_nxt;
  logic             err_nxt;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    word_cnt_nxt = word_cnt_o;
    err_nxt      = err_o;
    case (state)
      ST_RUN: begin
        cnt_nxt = '0;
        if (prog_req) state_nxt = ST_ENTER;
      end
      ST_ENTER: begin
        if (cnt == HOLD_LAST) begin
          state_nxt    = ST_PROG;
          cnt_nxt      = '0;
          word_cnt_nxt = '0;
          err_nxt      = 1'b0;
        end
      end
      ST_PROG: begin
        // The counter measures idle time, so every accepted word restarts it
        if (upg_wen_i) begin
          cnt_nxt = '0;
          if (word_cnt_o != 16'hFFFF) word_cnt_nxt = word_cnt_o + 16'd1;
        end
        if (upg_done_i) begin
          state_nxt = ST_EXIT;
          cnt_nxt   = '0;
        end else if (!upg_wen_i && cnt == TIMEOUT_LAST) begin
          state_nxt = ST_EXIT;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      ST_EXIT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      word_cnt_o <= '0;
      err_o      <= 1'b0;
      cpu_rst_o  <= 1'b1;
      upg_rst_o  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      word_cnt_o <= word_cnt_nxt;
      err_o      <= err_nxt;
      cpu_rst_o  <= (state_nxt != ST_RUN);
      upg_rst_o  <= (state_nxt != ST_PROG);
    end
  end

  assign mode_o = state;

  upg_mem_mux u_mem_mux (
    .rst      (rst),
    .state    (state),
    .upg_wen  (upg_wen_i),
    .upg_adr  (upg_adr_i),
    .upg_dat  (upg_dat_i),
    .cpu_dwen (cpu_dwen_i),
    .cpu_dadr (cpu_dadr_i),
    .cpu_ddat (cpu_ddat_i),
    .imem_wen (imem_wen_o),
    .imem_adr (imem_adr_o),
    .imem_dat (imem_dat_o),
    .dmem_wen (dmem_wen_o),
    .dmem_adr (dmem_adr_o),
    .dmem_dat (dmem_dat_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_upg_arbiter.sv
// ============================================================================
// tb_upg_arbiter : scoreboard bench for the UART program-load arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_upg_arbiter;

  localparam int HOLD = 16;
  localparam int TMO  = 100;

  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] adr;
    logic [31:0] dat;
  } wr_t;

  localparam logic [1:0] K_IMEM = 2'd1;
  localparam logic [1:0] K_DMEM = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_req = 1'b0;
  logic        upg_wen_i = 1'b0;
  logic [14:0] upg_adr_i = '0;
  logic [31:0] upg_dat_i = '0;
  logic        upg_done_i = 1'b0;
  logic        cpu_dwen_i = 1'b0;
  logic [13:0] cpu_dadr_i = '0;
  logic [31:0] cpu_ddat_i = '0;
  logic        imem_wen_o;
  logic [13:0] imem_adr_o;
  logic [31:0] imem_dat_o;
  logic        dmem_wen_o;
  logic [13:0] dmem_adr_o;
  logic [31:0] dmem_dat_o;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic [1:0]  mode_o;
  logic [15:0] word_cnt_o;
  logic        err_o;

  int  vectors = 0;
  int  miscompares = 0;
  wr_t exp_q[$];
  wr_t exp_w;
  wr_t obs_w;

  logic [14:0] wr_adr [4] = '{15'h0003, 15'h4005, 15'h7FFF, 15'h3FFF};
  logic [31:0] wr_dat [4] = '{32'h0000_0013, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D};

  upg_arbiter #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_req   (prog_req),
    .upg_wen_i  (upg_wen_i),
    .upg_adr_i  (upg_adr_i),
    .upg_dat_i  (upg_dat_i),
    .upg_done_i (upg_done_i),
    .cpu_dwen_i (cpu_dwen_i),
    .cpu_dadr_i (cpu_dadr_i),
    .cpu_ddat_i (cpu_ddat_i),
    .imem_wen_o (imem_wen_o),
    .imem_adr_o (imem_adr_o),
    .imem_dat_o (imem_dat_o),
    .dmem_wen_o (dmem_wen_o),
    .dmem_adr_o (dmem_adr_o),
    .dmem_dat_o (dmem_dat_o),
    .upg_rst_o  (upg_rst_o),
    .cpu_rst_o  (cpu_rst_o),
    .mode_o     (mode_o),
    .word_cnt_o (word_cnt_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  function automatic wr_t observed();
    if (imem_wen_o && dmem_wen_o) return wr_t'{2'd3, imem_adr_o, imem_dat_o};
    if (imem_wen_o) return wr_t'{K_IMEM, imem_adr_o, imem_dat_o};
    if (dmem_wen_o) return wr_t'{K_DMEM, dmem_adr_o, dmem_dat_o};
    return '0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_dwen_i = 1'b1; cpu_dadr_i = 14'h0022; cpu_ddat_i = 32'h0102_0304;
    exp_q.push_back('0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL reset_wen_gate: got %h expected %h", obs_w, exp_w);
    end
    vectors++;
    if ({mode_o, cpu_rst_o, upg_rst_o, word_cnt_o, err_o} !== {2'd0, 1'b1, 1'b1, 16'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got mode=%0d cpu_rst=%b upg_rst=%b wc=%0d err=%b expected 0 1 1 0 0",
               mode_o, cpu_rst_o, upg_rst_o, word_cnt_o, err_o);
    end
    next_cycle();
    rst = 1'b0; cpu_dwen_i = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (cpu_rst_o !== 1'b0 || upg_rst_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got cpu_rst=%b upg_rst=%b expected 0 1", cpu_rst_o, upg_rst_o);
    end
  endtask

  task automatic test_run_passthrough();
    next_cycle();
    cpu_dwen_i = 1'b1; cpu_dadr_i = 14'h0010; cpu_ddat_i = 32'hA5A5_A5A5;
    exp_q.push_back(wr_t'{K_DMEM, 14'h0010, 32'hA5A5_A5A5});
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL run_cpu_write: got %h expected %h", obs_w, exp_w);
    end
    vectors++;
    if ({mode_o, imem_adr_o, imem_dat_o} !== {2'd0, 14'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL run_imem_idle: got mode=%0d iadr=%h idat=%h expected 0 0 0", mode_o, imem_adr_o, imem_dat_o);
    end
    next_cycle();
    cpu_dwen_i = 1'b0; cpu_dadr_i = 14'h3FFF; cpu_ddat_i = 32'h5A5A_5A5A;
    exp_q.push_back('0);
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w || dmem_adr_o !== 14'h3FFF) begin
      miscompares++;
      $display("FAIL run_no_write: got %h dadr=%h expected %h dadr=3fff", obs_w, dmem_adr_o, exp_w);
    end
  endtask

  task automatic test_enter();
    int n;
    next_cycle();
    prog_req = 1'b1;
    next_cycle();
    prog_req = 1'b0;
    cpu_dwen_i = 1'b1; cpu_dadr_i = 14'h0040; cpu_ddat_i = 32'hFFFF_0000;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 40 && mode_o == 2'd1; i++) begin
      n++;
      vectors++;
      if (cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 || dmem_wen_o !== 1'b0 || imem_wen_o !== 1'b0) begin
        miscompares++;
        $display("FAIL enter_hold: got cpu_rst=%b upg_rst=%b dwen=%b iwen=%b expected 1 1 0 0",
                 cpu_rst_o, upg_rst_o, dmem_wen_o, imem_wen_o);
      end
      next_cycle();
      @(negedge clk);
    end
    vectors++;
    if (n !== HOLD) begin
      miscompares++;
      $display("FAIL enter_cycles: got %0d expected %0d", n, HOLD);
    end
    vectors++;
    if ({mode_o, upg_rst_o, cpu_rst_o, word_cnt_o, err_o} !== {2'd2, 1'b0, 1'b1, 16'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL prog_entry: got mode=%0d upg_rst=%b cpu_rst=%b wc=%0d err=%b expected 2 0 1 0 0",
               mode_o, upg_rst_o, cpu_rst_o, word_cnt_o, err_o);
    end
  endtask

  task automatic test_prog_writes();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      upg_wen_i = 1'b1; upg_adr_i = wr_adr[i]; upg_dat_i = wr_dat[i];
      exp_q.push_back(wr_t'{(wr_adr[i][14] ? K_DMEM : K_IMEM), wr_adr[i][13:0], wr_dat[i]});
      @(negedge clk);
      exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
      if (obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL prog_write[%0d]: got %h expected %h", i, obs_w, exp_w);
      end
      if (i == 2) begin
        vectors++;
        if (word_cnt_o !== 16'd2) begin
          miscompares++;
          $display("FAIL prog_word_cnt2: got %0d expected 2", word_cnt_o);
        end
      end
    end
    next_cycle();
    upg_wen_i = 1'b0;
    exp_q.push_back('0);
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w || word_cnt_o !== 16'd4) begin
      miscompares++;
      $display("FAIL prog_idle: got %h wc=%0d expected %h wc=4", obs_w, word_cnt_o, exp_w);
    end
  endtask

  task automatic test_done_with_write();
    int n;
    next_cycle();
    upg_wen_i = 1'b1; upg_adr_i = 15'h0007; upg_dat_i = 32'h0BAD_F00D; upg_done_i = 1'b1;
    exp_q.push_back(wr_t'{K_IMEM, 14'h0007, 32'h0BAD_F00D});
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL done_write: got %h expected %h", obs_w, exp_w);
    end
    next_cycle();
    upg_wen_i = 1'b0; upg_done_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mode_o, word_cnt_o} !== {2'd3, 16'd5}) begin
      miscompares++;
      $display("FAIL done_exit: got mode=%0d wc=%0d expected 3 5", mode_o, word_cnt_o);
    end
    n = 0;
    for (int i = 0; i < 40 && mode_o == 2'd3; i++) begin
      n++;
      vectors++;
      if (cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 || dmem_wen_o !== 1'b0) begin
        miscompares++;
        $display("FAIL exit_hold: got cpu_rst=%b upg_rst=%b dwen=%b expected 1 1 0", cpu_rst_o, upg_rst_o, dmem_wen_o);
      end
      next_cycle();
      @(negedge clk);
    end
    vectors++;
    if (n !== HOLD) begin
      miscompares++;
      $display("FAIL exit_cycles: got %0d expected %0d", n, HOLD);
    end
    vectors++;
    if ({mode_o, cpu_rst_o, err_o, dmem_wen_o} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL run_resume: got mode=%0d cpu_rst=%b err=%b dwen=%b expected 0 0 0 1",
               mode_o, cpu_rst_o, err_o, dmem_wen_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    next_cycle();
    cpu_dwen_i = 1'b0; prog_req = 1'b1;
    next_cycle();
    prog_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40 && mode_o == 2'd1; i++) begin
      next_cycle();
      @(negedge clk);
    end
    vectors++;
    if (mode_o !== 2'd2) begin
      miscompares++;
      $display("FAIL timeout_prog_entry: got mode=%0d expected 2", mode_o);
    end
    n = 0;
    for (int i = 0; i < 300 && mode_o == 2'd2; i++) begin
      n++;
      next_cycle();
      prog_req = (n == 50);
      @(negedge clk);
    end
    prog_req = 1'b0;
    vectors++;
    if (n !== TMO) begin
      miscompares++;
      $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO);
    end
    vectors++;
    if ({mode_o, err_o, word_cnt_o} !== {2'd3, 1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL timeout_exit: got mode=%0d err=%b wc=%0d expected 3 1 0", mode_o, err_o, word_cnt_o);
    end
    for (int i = 0; i < 40 && mode_o == 2'd3; i++) begin
      next_cycle();
      @(negedge clk);
    end
    vectors++;
    if ({mode_o, err_o, cpu_rst_o} !== {2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_sticky: got mode=%0d err=%b cpu_rst=%b expected 0 1 0", mode_o, err_o, cpu_rst_o);
    end
    next_cycle();
    prog_req = 1'b1;
    next_cycle();
    prog_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40 && mode_o == 2'd1; i++) begin
      next_cycle();
      @(negedge clk);
    end
    vectors++;
    if ({mode_o, err_o} !== {2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL err_clear: got mode=%0d err=%b expected 2 0", mode_o, err_o);
    end
  endtask

  task automatic test_rst_mid_prog();
    next_cycle();
    upg_wen_i = 1'b1; upg_adr_i = 15'h4001; upg_dat_i = 32'h1111_2222;
    exp_q.push_back(wr_t'{K_DMEM, 14'h0001, 32'h1111_2222});
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL rst_pre_write: got %h expected %h", obs_w, exp_w);
    end
    next_cycle();
    upg_adr_i = 15'h0009; upg_dat_i = 32'h3333_4444; rst = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    exp_w = exp_q.pop_front(); obs_w = observed(); vectors++;
    if (obs_w !== exp_w || word_cnt_o !== 16'd1) begin
      miscompares++;
      $display("FAIL rst_write_blocked: got %h wc=%0d expected %h wc=1", obs_w, word_cnt_o, exp_w);
    end
    next_cycle();
    rst = 1'b0; upg_wen_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mode_o, word_cnt_o, upg_rst_o, cpu_rst_o, err_o} !== {2'd0, 16'd0, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid_prog: got mode=%0d wc=%0d upg_rst=%b cpu_rst=%b err=%b expected 0 0 1 1 0",
               mode_o, word_cnt_o, upg_rst_o, cpu_rst_o, err_o);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (cpu_rst_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_prog_release: got cpu_rst=%b expected 0", cpu_rst_o);
    end
  endtask

  initial begin
    test_reset();
    test_run_passthrough();
    test_enter();
    test_prog_writes();
    test_done_with_write();
    test_timeout();
    test_rst_mid_prog();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule

`default_nettype wire
